// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle.
// Groups the memory read port, instruction-register strobes, the decode handshake and the
// control-unit PC/halt inputs into one interface.
//   master : the fetch sequencer (drives mem_read, address, ir_*, instr_valid, halted,
//            pc_out, instr_count; receives mem_ready, instr_accept, pc_load, pc_in, halt)
//   slave  : memory / instruction register / decode / control unit side
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  mem_ready;
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] address;
  logic                  ir_write;
  logic                  ir_lh;
  logic                  instr_valid;
  logic                  instr_accept;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_in;
  logic                  halt;
  logic                  halted;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic [15:0]           instr_count;

  modport master (
    input  mem_ready, instr_accept, pc_load, pc_in, halt,
    output mem_read, address, ir_write, ir_lh, instr_valid, halted, pc_out, instr_count
  );

  modport slave (
    output mem_ready, instr_accept, pc_load, pc_in, halt,
    input  mem_read, address, ir_write, ir_lh, instr_valid, halted, pc_out, instr_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, reads two consecutive bytes (low half at PC, high half at
// PC+1) into the 16-bit instruction register, then offers the instruction to decode with a
// valid/accept handshake. On accept, the control unit may redirect the PC and/or halt.
// Ports:
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset
//   bus    : fetch_sequencer_if.master (memory, IR strobes, decode handshake, control)
module fetch_sequencer #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {StFetchL, StFetchH, StValid, StHalt} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           count_q, count_d;

  logic mem_read, ir_write, ir_lh, instr_valid, halted;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    mem_read    = 1'b0;
    ir_write    = 1'b0;
    ir_lh       = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      StFetchL: begin
        mem_read = 1'b1;
        // Same-edge capture: the IR latches the bus on the edge that advances the PC.
        ir_write = bus.mem_ready;
        if (bus.mem_ready) begin
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = StFetchH;
        end
      end
      StFetchH: begin
        mem_read = 1'b1;
        ir_lh    = 1'b1;
        ir_write = bus.mem_ready;
        if (bus.mem_ready) begin
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = StValid;
        end
      end
      StValid: begin
        instr_valid = 1'b1;
        if (bus.instr_accept) begin
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
          if (bus.pc_load) begin
            pc_d = bus.pc_in;
          end
          state_d = bus.halt ? StHalt : StFetchL;
        end
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StFetchL;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFetchL;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // Reset puts the FSM in StFetchL, which would otherwise request a read; hold every
  // strobe low for as long as reset is asserted.
  assign bus.mem_read    = mem_read & rst_ni;
  assign bus.ir_write    = ir_write & rst_ni;
  assign bus.ir_lh       = ir_lh & rst_ni;
  assign bus.instr_valid = instr_valid & rst_ni;
  assign bus.halted      = halted & rst_ni;

  assign bus.address     = pc_q;
  assign bus.pc_out      = pc_q;
  assign bus.instr_count = count_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream control stage for the 16-bit instruction register, which loads one byte per write from the 8-bit memory data bus.
- Owns the program counter and drives the memory address and read request.
- Generates the register's Write and LH strobes so a full 16-bit instruction is assembled from two consecutive bytes.
- Presents the finished instruction to decode with a valid/accept handshake, and takes branch/jump PC loads and halt from the control unit.

Parameters:
- ADDR_WIDTH, 16, width of PC and memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- Clock  input  1  rising-edge system clock.
- Reset  input  1  asynchronous, active-low reset.
- MemReady  input  1  memory data bus holds valid byte for current Address this cycle.
- MemRead  output  1  read request to memory.
- Address  output  ADDR_WIDTH  memory byte address (equals PC).
- IRWrite  output  1  instruction register Write strobe.
- IRLH  output  1  instruction register half select (0 = IR[7:0], 1 = IR[15:8]).
- InstrValid  output  1  full instruction present in instruction register.
- InstrAccept  input  1  decode consumes instruction (sampled only while InstrValid=1).
- PCLoad  input  1  load PCIn as next fetch address (sampled only on accept).
- PCIn  input  ADDR_WIDTH  branch/jump target.
- Halt  input  1  stop fetching after current instruction (sampled only on accept).
- Halted  output  1  sequencer in HALT state.
- PCOut  output  ADDR_WIDTH  current PC, for PC-relative address calculation.
- InstrCount  output  16  number of accepted instructions, saturating at 0xFFFF.

Behaviour:
- Reset (Reset=0, asynchronous, any state including mid-fetch):
  - PC=RESET_PC, state=FETCH_L, InstrCount=0.
  - All strobes deasserted while Reset is held.
  - Instruction register contents after a reset are don't-care until the next assembly completes.
- Byte order: the byte at PC is the low half (IRLH=0); the byte at PC+1 is the high half (IRLH=1).
- States: FETCH_L, FETCH_H, VALID, HALT. Encoding is free.
- Address=PC and PCOut=PC in all states.
- FETCH_L:
  - MemRead=1, IRLH=0.
  - IRWrite=MemReady, combinational, so the register captures the bus on the same edge.
  - On MemReady=1: PC<=PC+1, go to FETCH_H.
  - Otherwise hold with no side effects; unbounded wait is allowed.
- FETCH_H:
  - MemRead=1, IRLH=1, IRWrite=MemReady.
  - On MemReady=1: PC<=PC+1, go to VALID.
- VALID:
  - InstrValid=1, MemRead=0, IRWrite=0, IRLH=0.
  - If InstrAccept=1:
    - InstrCount+1, holding at 0xFFFF.
    - PC<=PCIn if PCLoad=1, else unchanged.
    - Go to HALT if Halt=1, else FETCH_L.
  - Halt and PCLoad together: PC takes PCIn, then the block halts.
- HALT:
  - Halted=1; all other strobes 0; PC frozen.
  - Leaves HALT only via Reset.
- In all states other than VALID, PCLoad, Halt and InstrAccept are ignored.
- Minimum latency from entering FETCH_L to InstrValid=1 is 2 cycles (MemReady=1 on both fetch cycles). Back-to-back throughput is 3 cycles per instruction.
- PC arithmetic is modulo 2^ADDR_WIDTH: 0xFFFF+1 becomes 0x0000, with no error flag.
- The sequencer never issues IRWrite while InstrValid=1, so the instruction register is stable for decode.
- All state and PC updates happen on the rising Clock edge; outputs are decoded from the current state plus MemReady.

Test Plan:
- Reset release, MemReady tied 1, InstrAccept tied 1 -> Address sequence 0,1,(VALID),2,3.
  - IRWrite/IRLH pulses (1,0),(1,1) per instruction.
  - InstrValid every 3rd cycle; InstrCount=1,2,3.
- MemReady held low 4 cycles in FETCH_L at PC=0x0010 -> MemRead=1 and Address=0x0010 steady, IRWrite=0, PC unchanged; advances on the first MemReady=1.
- In VALID with PC=0x0022: InstrAccept=1, PCLoad=1, PCIn=0x0100 -> next Address=0x0100, IRLH=0.
  - Repeat with PCLoad=1, InstrAccept=0 -> ignored, stays VALID.
- PC=0xFFFF in FETCH_L, MemReady=1 -> FETCH_H Address=0x0000 -> VALID with PC=0x0001.
- Reset asserted mid-FETCH_H at PC=0x0041 -> immediately MemRead=0, IRWrite=0; after release Address=RESET_PC, state FETCH_L, InstrCount=0.
- Accept with Halt=1 -> Halted=1, MemRead stays 0 for 20 cycles regardless of MemReady.
  - Separately: force InstrCount to 0xFFFF, accept one more -> InstrCount stays 0xFFFF.
